// File: rtl/seq_subtractor_64bit.sv
`default_nettype none
// ============================================================================
//  Module      : seq_subtractor_64bit
//  Description : Multi-cycle WIDTH-bit subtractor D = A - B - Bi, one CHUNK-bit
//                slice per clock with a registered borrow between slices.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_subtractor_64bit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Bi,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Ready,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] D,
  output logic             Bo,
  output logic             Ovf
);

  localparam int c_nch  = WIDTH / CHUNK;
  localparam int c_idxw = (c_nch > 1) ? $clog2(c_nch) : 1;
  localparam logic [c_idxw-1:0] c_last = c_idxw'(c_nch - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]        r_state;
  logic [c_idxw-1:0] r_idx;
  logic              r_borrow;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_work;
  logic [WIDTH-1:0]  r_d;
  logic              r_bo;
  logic              r_ovf;

  logic              w_accept;
  logic              w_last;
  logic [CHUNK-1:0]  w_a_sl;
  logic [CHUNK-1:0]  w_b_sl;
  logic [CHUNK:0]    w_sub;
  logic [WIDTH-1:0]  w_result;

  assign Ready    = (r_state != c_run);
  assign Busy     = (r_state == c_run);
  assign Done     = (r_state == c_done);
  assign D        = r_d;
  assign Bo       = r_bo;
  assign Ovf      = r_ovf;

  assign w_accept = Start && Ready;
  assign w_last   = (r_idx == c_last);
  assign w_a_sl   = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_sl   = r_b[r_idx*CHUNK +: CHUNK];
  // Extra top bit of the slice difference is the borrow into the next slice
  assign w_sub    = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{CHUNK{1'b0}}, r_borrow};

  // Working register with the slice being computed this cycle merged in
  always_comb begin
    w_result = r_work;
    w_result[r_idx*CHUNK +: CHUNK] = w_sub[CHUNK-1:0];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= c_idle;
      r_idx    <= '0;
      r_borrow <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_work   <= '0;
      r_d      <= '0;
      r_bo     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        c_run: begin
          r_work   <= w_result;
          r_borrow <= w_sub[CHUNK];
          if (w_last) begin
            r_d     <= w_result;
            r_bo    <= w_sub[CHUNK];
            r_ovf   <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                       (w_result[WIDTH-1] != r_a[WIDTH-1]);
            r_idx   <= '0;
            r_state <= c_done;
          end else begin
            r_idx   <= r_idx + 1'b1;
          end
        end
        default: begin
          // IDLE and DONE both accept; DONE falls back to IDLE otherwise
          if (w_accept) begin
            r_a      <= A;
            r_b      <= B;
            r_borrow <= Bi;
            r_idx    <= '0;
            r_state  <= c_run;
          end else begin
            r_state  <= c_idle;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
